// File: rtl/net_fanout_pkg.sv
// Shared types and helpers for the broadcast-net round-robin scheduler.
package net_fanout_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_GRP   = 3;
    localparam int unsigned DEF_MAX_BURST = 4;

    // Widest requester vector the rotate-priority helper supports.
    localparam int unsigned PICK_MAX   = 8;
    localparam int unsigned PICK_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef logic [DEF_NUM_GRP-1:0] grp_mask_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        grp_mask_t             grp_en;
    } beat_t;

    // First valid index strictly after 'last', wrapping modulo n; 0 when nothing is valid.
    function automatic logic [PICK_IDX_W-1:0] rr_next(
        input logic [PICK_MAX-1:0]   valid_vec,
        input logic [PICK_IDX_W-1:0] last,
        input int unsigned           n
    );
        logic [PICK_IDX_W-1:0] win;
        logic [PICK_IDX_W-1:0] sel;
        logic                  found;
        int unsigned           idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= PICK_MAX; k++) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                sel = PICK_IDX_W'(idx);
                if (!found && valid_vec[sel]) begin
                    win   = sel;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/net_fanout_rr_scheduler_if.sv
// Requester and broadcast-side signals of the fanout scheduler.
interface net_fanout_rr_scheduler_if
    import net_fanout_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_GRP = DEF_NUM_GRP
) ();

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ*NUM_GRP-1:0] req_grp_mask;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       bcast_valid;
    logic [DATA_W-1:0]          bcast_data;
    logic [NUM_GRP-1:0]         bcast_grp_en;
    logic                       bcast_ready;

    logic [IDX_W-1:0]           grant_id;
    logic                       busy;

    // Requester wrappers plus the fanout tree.
    modport master (
        output req_valid, req_data, req_last, req_grp_mask, bcast_ready,
        input  req_ready, bcast_valid, bcast_data, bcast_grp_en, grant_id, busy
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_data, req_last, req_grp_mask, bcast_ready,
        output req_ready, bcast_valid, bcast_data, bcast_grp_en, grant_id, busy
    );

endinterface

// File: rtl/net_fanout_rr_pick.sv
// Combinational rotate-priority picker: first valid requester after the last winner.
module net_fanout_rr_pick
    import net_fanout_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner_c,
    output logic               any_c
);

    logic [PICK_MAX-1:0] valid_ext;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        winner_c                 = IDX_W'(rr_next(valid_ext, PICK_IDX_W'(last), NUM_REQ));
        any_c                    = |valid;
    end

endmodule

// File: rtl/net_fanout_rr_scheduler.sv
// Round-robin owner of a single buffered broadcast net feeding NUM_GRP load groups.
module net_fanout_rr_scheduler
    import net_fanout_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_GRP   = DEF_NUM_GRP,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    net_fanout_rr_scheduler_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t             state;
    logic [IDX_W-1:0]   grant_id_q;
    logic [IDX_W-1:0]   last_winner;
    logic [CNT_W-1:0]   beat_cnt;
    logic               busy_q;
    logic               bcast_valid_q;
    logic [DATA_W-1:0]  bcast_data_q;
    logic [NUM_GRP-1:0] bcast_grp_en_q;

    logic               slot_free_c;
    logic               own_valid_c;
    logic               own_last_c;
    logic [DATA_W-1:0]  own_data_c;
    logic [NUM_GRP-1:0] own_mask_c;
    logic               xfer_c;
    logic               burst_done_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [IDX_W-1:0]   winner_c;
    logic               any_c;

    net_fanout_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid    (bus.req_valid),
        .last     (last_winner),
        .winner_c (winner_c),
        .any_c    (any_c)
    );

    // Owner's view of the request bus and the single-slot transfer condition.
    always_comb begin
        slot_free_c  = !bcast_valid_q || bus.bcast_ready;
        own_valid_c  = bus.req_valid[grant_id_q];
        own_last_c   = bus.req_last[grant_id_q];
        own_data_c   = bus.req_data[grant_id_q*DATA_W +: DATA_W];
        own_mask_c   = bus.req_grp_mask[grant_id_q*NUM_GRP +: NUM_GRP];
        xfer_c       = (state == OWN) && own_valid_c && slot_free_c;
        burst_done_c = (beat_cnt == CNT_W'(MAX_BURST - 1));
        req_ready_c  = '0;
        if (xfer_c) begin
            req_ready_c[grant_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant_id_q     <= '0;
            last_winner    <= IDX_W'(NUM_REQ - 1);
            beat_cnt       <= '0;
            busy_q         <= 1'b0;
            bcast_valid_q  <= 1'b0;
            bcast_data_q   <= '0;
            bcast_grp_en_q <= '0;
        end else begin
            // Output slot: load on transfer, otherwise empty once downstream takes it.
            if (xfer_c) begin
                bcast_valid_q  <= 1'b1;
                bcast_data_q   <= own_data_c;
                bcast_grp_en_q <= own_mask_c;
            end else if (bus.bcast_ready) begin
                bcast_valid_q  <= 1'b0;
                bcast_grp_en_q <= '0;
            end

            case (state)
                IDLE: begin
                    if (any_c) begin
                        grant_id_q <= winner_c;
                        beat_cnt   <= '0;
                        state      <= OWN;
                        busy_q     <= 1'b1;
                    end
                end
                OWN: begin
                    if (xfer_c) begin
                        if (own_last_c || burst_done_c) begin
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            last_winner <= grant_id_q;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end else if (!own_valid_c) begin
                        // Owner went quiet: hand the net back rather than idle on it.
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        last_winner <= grant_id_q;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.bcast_valid  = bcast_valid_q;
    assign bus.bcast_data   = bcast_data_q;
    assign bus.bcast_grp_en = bcast_grp_en_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_bcast_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.bcast_valid && !bus.bcast_ready) |=>
            (bus.bcast_valid && $stable(bus.bcast_data) && $stable(bus.bcast_grp_en)));

    a_grp_en_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.bcast_valid |-> (bus.bcast_grp_en == '0));

endmodule

// File: tb/tb_net_fanout_rr_scheduler.sv
// Directed scoreboard bench for net_fanout_rr_scheduler.
module tb_net_fanout_rr_scheduler;
    import net_fanout_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NG = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [NG-1:0] mask;
    } rq_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rq_t   rq [NR][$];
    beat_t exp_q [$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int unsigned exp_g [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    net_fanout_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .NUM_GRP(NG)) bus ();

    net_fanout_rr_scheduler #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .NUM_GRP   (NG),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Present the head of every requester queue on the bus.
    task automatic drive();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        logic [NR*NG-1:0] m;
        v = '0; l = '0; d = '0; m = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) begin
                v[i]           = 1'b1;
                l[i]           = rq[i][0].last;
                d[i*DW +: DW]  = rq[i][0].data;
                m[i*NG +: NG]  = rq[i][0].mask;
            end
        end
        bus.req_valid    = v;
        bus.req_last     = l;
        bus.req_data     = d;
        bus.req_grp_mask = m;
    endtask

    // One clock: sample acceptance mid-cycle, then advance the requesters after the edge.
    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        end
        drive();
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic l, input logic [2:0] m);
        rq[r].push_back('{data: d, last: l, mask: m});
    endtask

    task automatic expb(input logic [7:0] d, input logic [2:0] m);
        exp_q.push_back('{data: d, grp_en: m});
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        drive();
        bus.bcast_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int maxc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || pending()) && c < maxc) begin
            step();
            c++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        repeat (2) step();
    endtask

    // Monitor: every accepted broadcast beat must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.bcast_valid && bus.bcast_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.bcast_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bcast_data", 32'(bus.bcast_data), 32'(mon_e.data));
                chk("bcast_grp_en", 32'(bus.bcast_grp_en), 32'(mon_e.grp_en));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        // Single requester, three beats, mask 101.
        do_reset();
        add(1, 8'h11, 1'b0, 3'b101);
        add(1, 8'h22, 1'b0, 3'b101);
        add(1, 8'h33, 1'b1, 3'b101);
        expb(8'h11, 3'b101); expb(8'h22, 3'b101); expb(8'h33, 3'b101);
        drive();
        #1;
        chk("rst_bcast_valid", 32'(bus.bcast_valid), 32'd0);
        chk("rst_bcast_data", 32'(bus.bcast_data), 32'd0);
        chk("rst_grp_en", 32'(bus.bcast_grp_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
        step(); #1;
        chk("t1_c1_req_ready", 32'(bus.req_ready), 32'b0010);
        chk("t1_c1_grant", 32'(bus.grant_id), 32'd1);
        chk("t1_c1_bvalid", 32'(bus.bcast_valid), 32'd0);
        step(); #1;
        chk("t1_c2_bvalid", 32'(bus.bcast_valid), 32'd1);
        step(); #1;
        chk("t1_c3_bvalid", 32'(bus.bcast_valid), 32'd1);
        chk("t1_c3_busy", 32'(bus.busy), 32'd1);
        step(); #1;
        chk("t1_c4_bvalid", 32'(bus.bcast_valid), 32'd1);
        chk("t1_c4_busy", 32'(bus.busy), 32'd0);
        step(); #1;
        chk("t1_c5_bvalid", 32'(bus.bcast_valid), 32'd0);
        drain("t1_drain", 20);

        // All four requesters, single-beat packets: 0,1,2,3,0 with idle gaps.
        do_reset();
        add(0, 8'h00, 1'b1, 3'b111);
        add(0, 8'h01, 1'b1, 3'b111);
        add(1, 8'h10, 1'b1, 3'b001);
        add(2, 8'h20, 1'b1, 3'b010);
        add(3, 8'h30, 1'b1, 3'b100);
        expb(8'h00, 3'b111); expb(8'h10, 3'b001); expb(8'h20, 3'b010);
        expb(8'h30, 3'b100); expb(8'h01, 3'b111);
        drive();
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk("t2_grant", 32'(bus.grant_id), 32'(exp_g[k]));
            chk("t2_own_busy", 32'(bus.busy), 32'd1);
            step(); #1;
            chk("t2_gap_busy", 32'(bus.busy), 32'd0);
        end
        drain("t2_drain", 20);

        // Burst limit: requester 2 loses the net after 4 beats to requester 3.
        do_reset();
        for (int b = 0; b < 6; b++) add(2, 8'(8'h20 + b), (b == 5), 3'b110);
        add(3, 8'h30, 1'b1, 3'b001);
        expb(8'h20, 3'b110); expb(8'h21, 3'b110); expb(8'h22, 3'b110);
        expb(8'h23, 3'b110); expb(8'h30, 3'b001); expb(8'h24, 3'b110);
        expb(8'h25, 3'b110);
        drive();
        drain("t3_drain", 60);

        // Backpressure for five cycles mid-burst.
        do_reset();
        for (int b = 0; b < 4; b++) add(1, 8'(8'h40 + b), (b == 3), 3'b011);
        for (int b = 0; b < 4; b++) expb(8'(8'h40 + b), 3'b011);
        drive();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(); #1;
            if (bus.bcast_valid && bus.bcast_data == 8'h40) seen = 1'b1;
        end
        chk("t4_first_beat_seen", 32'(seen), 32'd1);
        step();
        bus.bcast_ready = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            chk("t4_hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("t4_hold_data", 32'(bus.bcast_data), 32'h41);
            chk("t4_hold_grp_en", 32'(bus.bcast_grp_en), 32'b011);
            chk("t4_hold_busy", 32'(bus.busy), 32'd1);
            step(); #1;
        end
        bus.bcast_ready = 1'b1;
        drain("t4_drain", 30);

        // Owner drops valid; requester 0 (zero mask) gets the net after one idle cycle.
        do_reset();
        add(1, 8'h50, 1'b0, 3'b010);
        expb(8'h50, 3'b010); expb(8'h60, 3'b000);
        drive();
        step();
        step();
        add(0, 8'h60, 1'b1, 3'b000);
        drive();
        #1;
        chk("t5_c2_busy", 32'(bus.busy), 32'd1);
        step(); #1;
        chk("t5_c3_busy", 32'(bus.busy), 32'd0);
        chk("t5_c3_req_ready", 32'(bus.req_ready), 32'd0);
        step(); #1;
        chk("t5_c4_grant", 32'(bus.grant_id), 32'd0);
        chk("t5_c4_busy", 32'(bus.busy), 32'd1);
        chk("t5_c4_req_ready", 32'(bus.req_ready), 32'b0001);
        drain("t5_drain", 20);

        // Asynchronous reset mid-burst, then first grant goes to requester 0.
        do_reset();
        for (int b = 0; b < 4; b++) add(2, 8'(8'h70 + b), 1'b0, 3'b111);
        expb(8'h70, 3'b111);
        drive();
        repeat (3) step();
        #1;
        chk("t6_pre_busy", 32'(bus.busy), 32'd1);
        chk("t6_pre_bvalid", 32'(bus.bcast_valid), 32'd1);
        chk("t6_pre_sb_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bvalid", 32'(bus.bcast_valid), 32'd0);
        chk("t6_rst_data", 32'(bus.bcast_data), 32'd0);
        chk("t6_rst_grp_en", 32'(bus.bcast_grp_en), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
        flush();
        drive();
        #1;
        rst_n = 1'b1;
        step();
        add(0, 8'h80, 1'b1, 3'b001);
        add(3, 8'h90, 1'b1, 3'b100);
        expb(8'h80, 3'b001); expb(8'h90, 3'b100);
        drive();
        step(); #1;
        chk("t6_post_req_ready", 32'(bus.req_ready), 32'b0001);
        chk("t6_post_grant", 32'(bus.grant_id), 32'd0);
        drain("t6_drain", 20);

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
